// File: rtl/ones_detect_arbiter.sv
// Round-robin front end that time-shares one serial mod-4 ones-count detector among NREQ requesters.
// Define ONES_DET_CTX_EN to keep a per-requester count context that carries over from word to word.
module ones_detect_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         busy,
  output logic                         det_pulse,
  output logic                         done_valid,
  output logic [$clog2(NREQ)-1:0]      done_id,
  output logic [$clog2(WIDTH+1)-1:0]   done_count,
  output logic [1:0]                   o_dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH+1);
  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_grant;
  logic             w_any;
  logic [WIDTH-1:0] r_word;
  logic [1:0]       r_wcnt;
  logic [1:0]       w_start_cnt;
  logic [CW-1:0]    r_det_cnt;
  logic [BCW-1:0]   r_bitcnt;
  logic             r_det_pulse;
  logic             w_last_bit;
  logic             w_wrap;

  // Handshake: a word transfers in the IDLE cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready is combinational, one-hot, and only ever raised for the round-robin winner.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    // Scan from farthest to nearest so the first valid index after rr_ptr wins.
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_grant = IDW'((int'(r_rr_ptr) + k) % NREQ);
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any) req_ready[w_grant] = 1'b1;
  end

  assign w_last_bit = (r_bitcnt == BCW'(WIDTH-1));
  assign w_wrap     = (r_state == S_SHIFT) && r_word[0] && (r_wcnt == 2'd3);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef ONES_DET_CTX_EN
  logic [1:0] r_ctx [NREQ];

  assign w_start_cnt = r_ctx[w_grant];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_ctx[i] <= 2'd0;
    end else if (r_state == S_DONE) begin
      r_ctx[r_id] <= r_wcnt;
    end
  end
`else
  assign w_start_cnt = 2'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDW'(NREQ-1);
      r_id        <= '0;
      r_word      <= '0;
      r_wcnt      <= 2'd0;
      r_det_cnt   <= '0;
      r_bitcnt    <= '0;
      r_det_pulse <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_det_pulse <= w_wrap;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_word    <= req_data[w_grant*WIDTH +: WIDTH];
            r_id      <= w_grant;
            r_wcnt    <= w_start_cnt;
            r_det_cnt <= '0;
            r_bitcnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_word   <= r_word >> 1;
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_word[0]) r_wcnt <= r_wcnt + 2'd1;
          if (w_wrap) r_det_cnt <= r_det_cnt + 1'b1;
        end
        S_DONE: r_rr_ptr <= r_id;
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign det_pulse   = r_det_pulse;
  assign done_valid  = (r_state == S_DONE);
  assign done_id     = done_valid ? r_id : '0;
  assign done_count  = done_valid ? r_det_cnt : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ones_detect_arbiter.sv
// Scoreboard bench for ones_detect_arbiter: directed scenarios followed by randomized multi-requester traffic.
module tb_ones_detect_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int CW    = $clog2(WIDTH+1);
  localparam int W     = IDW + CW;
`ifdef ONES_DET_CTX_EN
  localparam bit CTX_EN = 1'b1;
`else
  localparam bit CTX_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  busy;
  logic                  det_pulse;
  logic                  done_valid;
  logic [IDW-1:0]        done_id;
  logic [CW-1:0]         done_count;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ones_detect_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .det_pulse(det_pulse),
    .done_valid(done_valid), .done_id(done_id), .done_count(done_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]    exp_q[$];
  bit              det_exp[int];
  int              m_rr;
  int              m_free_at;
  int              m_last_acc;
  int              m_ctx[NREQ];
  logic [NREQ-1:0] acc_flag;
  logic [NREQ-1:0] hold;
  bit              rand_en;
  int              n_checks = 0;
  int              n_pass = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    det_exp.delete();
    m_rr      = NREQ - 1;
    m_free_at = 0;
    for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
  endtask

  // Accept side: predict the grant, check req_ready, push the expected result.
  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_rdy;
    logic [WIDTH-1:0] w;
    int g, c, run, pop;
    if (!reset) begin
      exp_rdy = '0;
      g = -1;
      if (cyc >= m_free_at)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", int'(req_ready), int'(exp_rdy));
      acc_flag = acc_flag | req_ready;
      if (g >= 0) begin
        w   = req_data[g*WIDTH +: WIDTH];
        c   = CTX_EN ? m_ctx[g] : 0;
        run = c;
        pop = 0;
        for (int k = 0; k < WIDTH; k++)
          if (w[k]) begin
            run++;
            pop++;
            if (run % 4 == 0) det_exp[cyc + 2 + k] = 1'b1;
          end
        exp_q.push_back({IDW'(g), CW'((c + pop) / 4)});
        m_ctx[g]   = (c + pop) % 4;
        m_rr       = g;
        m_last_acc = cyc;
        m_free_at  = cyc + WIDTH + 2;
      end
    end
  end

  // Result side: check per-cycle status and pop the scoreboard on done_valid.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int de;
    if (!reset) begin
      de = det_exp.exists(cyc);
      check("det_pulse", int'(det_pulse), de);
      if (de != 0) det_exp.delete(cyc);
      check("busy", int'(busy), int'(m_free_at > 0 && cyc >= m_free_at - WIDTH - 1 && cyc < m_free_at));
      check("done_valid", int'(done_valid), int'(m_free_at > 0 && cyc == m_free_at - 1));
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got done_valid=1 expected no result (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_id", int'(done_id), int'(e[W-1:CW]));
          check("done_count", int'(done_count), int'(e[CW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (!hold[i]) begin
          req_valid[i] = 1'b0;
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      if (rand_en) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && cyc >= m_free_at && req_valid == '0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
    end
  endtask

  task automatic post(input int id, input logic [WIDTH-1:0] word);
    req_valid[id] = 1'b1;
    req_data[id*WIDTH +: WIDTH] = word;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_det_pulse"}, int'(det_pulse), 0);
    check({tag, "_done_valid"}, int'(done_valid), 0);
    check({tag, "_done_id"}, int'(done_id), 0);
    check({tag, "_done_count"}, int'(done_count), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    acc_flag  = '0;
    hold      = '0;
    rand_en   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;

    post(0, 8'hFF);                 wait_idle();
    post(1, 8'h07);                 wait_idle();
    post(1, 8'h01);                 wait_idle();
    post(2, 8'hAA);                 wait_idle();
    post(0, 8'h0F); post(3, 8'hF0); wait_idle();
    post(3, 8'h3C);                 wait_idle();

    // All four held continuously: five grants in rotation.
    hold = '1;
    post(0, 8'h11); post(1, 8'h5B); post(2, 8'hE7); post(3, 8'hFE);
    repeat (4 * (WIDTH + 2) + 5) step();
    hold = '0;
    req_valid = '0;
    wait_idle();

    // Reset in the middle of a SHIFT discards the word and clears contexts.
    post(0, 8'hFF);
    step();
    n = 0;
    while (cyc < m_last_acc + 4 && n < 50) begin
      step();
      n++;
    end
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    acc_flag = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    post(0, 8'h0F);                 wait_idle();

    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    req_valid = '0;
    wait_idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
